// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends one byte in an
// odd-parity frame clocked by the device, then checks the device acknowledge bit.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 3200,
    parameter int unsigned SETUP_CYCLES   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 64000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        WAIT_IDLE
    } state_t;

    state_t      state;
    logic        clk_s1, clk_s2, clk_prev;
    logic        data_s1, data_s2;
    logic        fall;
    logic [9:0]  shift;
    logic [3:0]  bit_cnt;
    logic [31:0] cnt;

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shift       <= 10'h3FF;
            bit_cnt     <= 4'd0;
            cnt         <= 32'd0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift       <= {1'b1, ~^tx_data, tx_data};
                        bit_cnt     <= 4'd0;
                        cnt         <= 32'd0;
                        ack_err     <= 1'b0;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INHIBIT_CYCLES - 1) begin
                        cnt         <= 32'd0;
                        ps2_data_oe <= 1'b1;
                        state       <= START;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                START: begin
                    if (cnt == SETUP_CYCLES - 1) begin
                        cnt        <= 32'd0;
                        ps2_clk_oe <= 1'b0;
                        state      <= SEND;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                SEND: begin
                    // The start bit stays on the line until the first device fall.
                    if (fall) begin
                        cnt <= 32'd0;
                        if (bit_cnt == 4'd10) begin
                            ack_err     <= data_s2;
                            ps2_data_oe <= 1'b0;
                            state       <= WAIT_IDLE;
                        end else begin
                            ps2_data_oe <= ~shift[0];
                            shift       <= {1'b1, shift[9:1]};
                            bit_cnt     <= bit_cnt + 4'd1;
                        end
                    end else if (cnt == TIMEOUT_CYCLES - 1) begin
                        timeout     <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s2 && data_s2) begin
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (fall) begin
                        cnt <= 32'd0;
                    end else if (cnt == TIMEOUT_CYCLES - 1) begin
                        timeout     <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
